// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Owns the program counter, drives the address of a
// combinational instruction memory, and captures the returned word into an
// instruction register that is offered to the decoder through a valid/ready
// handshake. Supports decoder back-pressure, redirect (jump/branch) and a
// HALT encoding that stops fetching until the next redirect.
//
// Ports
//   clk          in   1    clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   en           in   1    run enable; 0 stops issuing new fetches
//   ins_addr     out  AW   address to instruction memory (current pc)
//   ins_data     in   IW   instruction word returned in the same cycle
//   ir_out       out  IW   registered instruction to decoder
//   ir_pc        out  AW   address ir_out was fetched from
//   ir_valid     out  1    ir_out/ir_pc hold an unconsumed instruction
//   ir_ready     in   1    decoder accepts ir_out this cycle when ir_valid=1
//   redirect     in   1    load redirect_pc and flush the instruction register
//   redirect_pc  in   AW   redirect target
//   halted       out  1    1 while in the HALT state
//   fetch_cnt    out  16   instructions captured since reset, saturating
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int              AW        = 8,
    parameter int              IW        = 16,
    parameter logic [AW-1:0]   RESET_PC  = '0,
    parameter logic [IW-1:0]   HALT_WORD = 16'o177777
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [AW-1:0] ins_addr,
    input  logic [IW-1:0] ins_data,
    output logic [IW-1:0] ir_out,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          halted,
    output logic [15:0]   fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e        state_q,     state_d;
    logic [AW-1:0] pc_q,        pc_d;
    logic [IW-1:0] ir_q,        ir_d;
    logic [AW-1:0] ir_pc_q,     ir_pc_d;
    logic          ir_valid_q,  ir_valid_d;
    logic [15:0]   fetch_cnt_q, fetch_cnt_d;
    logic          halted_q;

    logic          slot_free;
    logic          fetch_go;
    logic          is_halt;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The register can take a new word if it is empty or being drained now.
    assign slot_free = !ir_valid_q || ir_ready;
    // Redirect wins over fetch so the old pc is never fetched alongside it.
    assign fetch_go  = (state_q == RUN) && en && slot_free && !redirect;
    assign is_halt   = (ins_data == HALT_WORD);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            IDLE: if (en)  state_d = RUN;
            RUN:  if (!en) state_d = IDLE;
            HALT: if (redirect) state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            // Flush: the held word is dropped even if the decoder takes it.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
        end else if (fetch_go) begin
            ir_d        = ins_data;
            ir_pc_d     = pc_q;
            ir_valid_d  = 1'b1;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
            if (is_halt) begin
                // pc parks on the HALT word so ins_addr keeps pointing at it.
                state_d = HALT;
            end else begin
                pc_d = pc_q + AW'(1);
            end
        end else if (ir_valid_q && ir_ready) begin
            // Drain without refill; ir_out/ir_pc keep the last word.
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            halted_q    <= (state_d == HALT);
        end
    end

    assign ins_addr  = pc_q;
    assign ir_out    = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Bench for ifetch_unit: a 256-word behavioural instruction memory, directed
// scenarios (sequential fetch, stall, redirect, wrap, HALT, mid-run reset) and
// a randomized run, all checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [IW-1:0] HWORD = 16'o177777;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] ins_addr;
    logic [IW-1:0] ins_data;
    logic [IW-1:0] ir_out;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;
    logic [15:0]   fetch_cnt;

    logic [IW-1:0] mem [256];

    always #5 clk = ~clk;

    assign ins_data = mem[ins_addr];

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ins_addr    (ins_addr),
        .ins_data    (ins_data),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fetch_cnt   (fetch_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural view of the fetch stage.
    // m_mode: 0 = stopped, 1 = running, 2 = halted
    int m_mode;
    int m_pc;
    int m_ir;
    int m_irpc;
    int m_cnt;
    bit m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_ir    = 0;
        m_irpc  = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    // One clock edge worth of behaviour, from the rules of the fetch stage.
    task automatic model_step(input bit e, input bit r, input bit rd, input int rpc);
        int nxt_mode;
        int word;
        nxt_mode = m_mode;
        if (m_mode == 0 && e)       nxt_mode = 1;
        else if (m_mode == 1 && !e) nxt_mode = 0;
        else if (m_mode == 2 && rd) nxt_mode = e ? 1 : 0;

        if (rd) begin
            m_pc    = rpc;
            m_valid = 1'b0;
        end else if (m_mode == 1 && e && (!m_valid || r)) begin
            word    = int'(mem[m_pc]);
            m_ir    = word;
            m_irpc  = m_pc;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (word == int'(HWORD)) nxt_mode = 2;
            else                     m_pc = (m_pc + 1) % 256;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        m_mode = nxt_mode;
    endtask

    task automatic check_all();
        chk("ir_out",    ir_out,    m_ir);
        chk("ir_pc",     ir_pc,     m_irpc);
        chk("ir_valid",  ir_valid,  m_valid);
        chk("halted",    halted,    (m_mode == 2));
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    // Drive one cycle: inputs set away from the edge, address checked before
    // the edge, registered outputs checked 1 time unit after it.
    task automatic cyc(input bit e, input bit r, input bit rd, input int rpc);
        en          = e;
        ir_ready    = r;
        redirect    = rd;
        redirect_pc = rpc[AW-1:0];
        #1;
        chk("ins_addr", ins_addr, m_pc);
        model_step(e, r, rd, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", ir_valid,  1'b0);
        chk("rst_addr",  ins_addr,  8'h00);
        chk("rst_cnt",   fetch_cnt, 16'h0000);
        chk("rst_halt",  halted,    1'b0);
        chk("rst_irout", ir_out,    16'h0000);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] wrap_pc [4];
        wrap_pc[0] = 8'hFE;
        wrap_pc[1] = 8'hFF;
        wrap_pc[2] = 8'h00;
        wrap_pc[3] = 8'h01;

        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom_range(0, 16'hFFFE));

        rst_n       = 1'b0;
        en          = 1'b0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();
        #12;
        check_all();
        chk("rst_addr0", ins_addr, 8'h00);
        rst_n = 1'b1;

        // Sequential fetch with a 3-cycle stall at ir_pc=4.
        cyc(1, 1, 0, 0);
        chk("t1_first_idle", ir_valid, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        chk("t2_pc4", ir_pc, 8'h04);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            chk("t2_frozen_pc",   ir_pc,    8'h04);
            chk("t2_frozen_addr", ins_addr, 8'h05);
            chk("t2_frozen_ir",   ir_out,   mem[4]);
        end
        cyc(1, 1, 0, 0);
        chk("t2_release", ir_pc, 8'h05);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        chk("t1_cnt10", fetch_cnt, 16'd10);
        chk("t1_pc9",   ir_pc,     8'h09);
        chk("t1_ir9",   ir_out,    mem[9]);

        // Redirect while stalled, with ir_ready asserted together.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 'h40);
        chk("t3_flush", ir_valid,  1'b0);
        chk("t3_cnt",   fetch_cnt, 16'd10);
        cyc(1, 1, 0, 0);
        chk("t3_target", ir_pc, 8'h40);

        // Wrap from 0xFF back to 0x00.
        cyc(1, 1, 1, 'hFE);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0);
            chk("t4_wrap", ir_pc, wrap_pc[i]);
        end
        chk("t4_cnt", fetch_cnt, 16'd15);

        // HALT word at address 3.
        mem[3] = HWORD;
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        chk("t5_ir",     ir_out,   HWORD);
        chk("t5_pc",     ir_pc,    8'h03);
        chk("t5_halted", halted,   1'b1);
        chk("t5_addr",   ins_addr, 8'h03);
        cyc(1, 1, 0, 0);
        chk("t5_drain",  ir_valid, 1'b0);
        cyc(1, 1, 0, 0);
        chk("t5_still",  halted,   1'b1);
        cyc(1, 1, 1, 0);
        chk("t5_resume", halted,   1'b0);
        cyc(1, 1, 0, 0);
        chk("t5_refetch", ir_out,  mem[0]);
        mem[3] = IW'($urandom_range(0, 16'hFFFE));

        // Reset mid-run, enable held high.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        reset_pulse();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t6_restart_pc", ir_pc,    8'h00);
        chk("t6_restart_v",  ir_valid, 1'b1);

        // Randomized run with sparse HALT words.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 31) == 0) ? HWORD : IW'($urandom_range(0, 16'hFFFE));
        for (int n = 0; n < 3000; n++) begin
            bit e;
            bit r;
            bit rd;
            e  = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 2) != 0);
            rd = e && (($urandom_range(0, 19) == 0) ||
                       (m_mode == 2 && $urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) reset_pulse();
            cyc(e, r, rd, int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
